phy_tx_lane: RTL

Transmit-side counterpart of the per-lane PHY receiver. It accepts one 8-bit symbol (data or K-code) per 10 fast-clock cycles through a ready/valid handshake, 8b/10b-encodes it with running disparity, and serializes the 10-bit code onto `data_bit`, bit 0 (`a`) first. It sits between the TX link/LTSSM symbol source and the physical line. Its bit order and encoding match what the receive lane expects: it shifts right and locks on K28.5 (RD− code 10'b0101_111100).

---
 rtl/phy_pkg.sv | 28 ++
 rtl/encoder_8b_10b.sv | 118 +++++++++++
 rtl/phy_tx_lane.sv | 94 +++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// Shared constants for the PHY lane: comma codes, idle/comma bytes and the legal K-byte set.
package phy_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

  localparam logic [9:0] COM_M    = 10'b0101111100;
  localparam logic [9:0] COM_P    = 10'b1010000011;
  localparam logic [7:0] K28_5    = 8'hBC;
  localparam logic [7:0] D0_0     = 8'h00;
  localparam logic [3:0] BIT_LAST = 4'd9;

  localparam int NUM_LEGAL_K = 12;
  localparam logic [7:0] LEGAL_K [NUM_LEGAL_K] = '{
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, K28_5, 8'hDC, 8'hFC,
    8'hF7, 8'hFB, 8'hFD, 8'hFE
  };

  function automatic logic is_legal_k(input logic [7:0] b);
    is_legal_k = 1'b0;
    for (int i = 0; i < NUM_LEGAL_K; i++) begin
      if (b == LEGAL_K[i]) is_legal_k = 1'b1;
    end
  endfunction

endpackage

// File: rtl/encoder_8b_10b.sv
// Combinational 8b/10b encoder with running disparity; illegal K bytes become K28.5.
module encoder_8b_10b
  import phy_pkg::*;
(
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out,
  output logic       k_err
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] base6, code6;
  logic [3:0] base4, code4;
  logic       flip6, unbal6, k28, rd_mid;
  logic       flip4, unbal4, alt7;
  logic [9:0] abc;

  assign x     = data[4:0];
  assign y     = data[7:5];
  assign k28   = k & (x == 5'd28);
  assign k_err = k & ~is_legal_k(data);

  // base6 is the RD- code in abcdei order; flip6 marks codes whose RD+ form is the complement
  always_comb begin
    {flip6, base6} = 7'b0_000000;
    case (x)
      5'd0:  {flip6, base6} = 7'b1_100111;
      5'd1:  {flip6, base6} = 7'b1_011101;
      5'd2:  {flip6, base6} = 7'b1_101101;
      5'd3:  {flip6, base6} = 7'b0_110001;
      5'd4:  {flip6, base6} = 7'b1_110101;
      5'd5:  {flip6, base6} = 7'b0_101001;
      5'd6:  {flip6, base6} = 7'b0_011001;
      5'd7:  {flip6, base6} = 7'b1_111000;
      5'd8:  {flip6, base6} = 7'b1_111001;
      5'd9:  {flip6, base6} = 7'b0_100101;
      5'd10: {flip6, base6} = 7'b0_010101;
      5'd11: {flip6, base6} = 7'b0_110100;
      5'd12: {flip6, base6} = 7'b0_001101;
      5'd13: {flip6, base6} = 7'b0_101100;
      5'd14: {flip6, base6} = 7'b0_011100;
      5'd15: {flip6, base6} = 7'b1_010111;
      5'd16: {flip6, base6} = 7'b1_011011;
      5'd17: {flip6, base6} = 7'b0_100011;
      5'd18: {flip6, base6} = 7'b0_010011;
      5'd19: {flip6, base6} = 7'b0_110010;
      5'd20: {flip6, base6} = 7'b0_001011;
      5'd21: {flip6, base6} = 7'b0_101010;
      5'd22: {flip6, base6} = 7'b0_011010;
      5'd23: {flip6, base6} = 7'b1_111010;
      5'd24: {flip6, base6} = 7'b1_110011;
      5'd25: {flip6, base6} = 7'b0_100110;
      5'd26: {flip6, base6} = 7'b0_010110;
      5'd27: {flip6, base6} = 7'b1_110110;
      5'd28: {flip6, base6} = 7'b0_001110;
      5'd29: {flip6, base6} = 7'b1_101110;
      5'd30: {flip6, base6} = 7'b1_011110;
      5'd31: {flip6, base6} = 7'b1_101011;
      default: {flip6, base6} = 7'b0_000000;
    endcase
    if (k28) {flip6, base6} = 7'b1_001111;
  end

  // D.7 alternates between 111000/000111 but is disparity-neutral
  assign unbal6 = flip6 & ~((x == 5'd7) & ~k28);
  assign code6  = (rd_in & flip6) ? ~base6 : base6;
  assign rd_mid = rd_in ^ unbal6;

  assign alt7 = (~rd_mid & ((x == 5'd17) | (x == 5'd18) | (x == 5'd20))) |
                ( rd_mid & ((x == 5'd11) | (x == 5'd13) | (x == 5'd14)));

  always_comb begin
    {flip4, base4} = 5'b0_0000;
    if (k) begin
      case (y)
        3'd0: {flip4, base4} = 5'b1_1011;
        3'd1: {flip4, base4} = 5'b1_0110;
        3'd2: {flip4, base4} = 5'b1_1010;
        3'd3: {flip4, base4} = 5'b1_1100;
        3'd4: {flip4, base4} = 5'b1_1101;
        3'd5: {flip4, base4} = 5'b1_0101;
        3'd6: {flip4, base4} = 5'b1_1001;
        default: {flip4, base4} = 5'b1_0111;
      endcase
    end else begin
      case (y)
        3'd0: {flip4, base4} = 5'b1_1011;
        3'd1: {flip4, base4} = 5'b0_1001;
        3'd2: {flip4, base4} = 5'b0_0101;
        3'd3: {flip4, base4} = 5'b1_1100;
        3'd4: {flip4, base4} = 5'b1_1101;
        3'd5: {flip4, base4} = 5'b0_1010;
        3'd6: {flip4, base4} = 5'b0_0110;
        default: {flip4, base4} = alt7 ? 5'b1_0111 : 5'b1_1110;
      endcase
    end
  end

  assign unbal4 = (y == 3'd0) | (y == 3'd4) | (y == 3'd7);
  assign code4  = (rd_mid & flip4) ? ~base4 : base4;
  assign abc    = {code6, code4};

  // Line order is a first, so code[0] = a and code[9] = j
  always_comb begin
    code   = '0;
    rd_out = rd_mid ^ unbal4;
    if (k_err) begin
      code   = rd_in ? COM_P : COM_M;
      rd_out = ~rd_in;
    end else begin
      for (int i = 0; i < 10; i++) code[i] = abc[9 - i];
    end
  end

endmodule

// File: rtl/phy_tx_lane.sv
// Per-lane PHY transmitter: ready/valid symbol intake, 8b/10b encode, LSB-first serializer.
module phy_tx_lane
  import phy_pkg::*;
(
  input  logic       clk_w_x10,
  input  logic       rstn_asyn,
  input  logic       tx_en,
  input  logic       sym_valid,
  input  logic [7:0] sym_data,
  input  logic       sym_k,
  output logic       sym_ready,
  output logic       data_bit,
  output logic       tx_active,
  output logic       sym_start,
  output logic       underrun,
  output logic       code_err
);

  tx_state_e  state_q;
  logic [3:0] bit_cnt_q;
  logic [9:0] tx_shift_q;
  logic       rd_q;
  logic       data_bit_q, tx_active_q, sym_start_q, underrun_q, code_err_q;

  logic       load;
  logic [7:0] enc_data;
  logic       enc_k;
  logic [9:0] shift_d;
  logic       rd_d, k_err_d;

  assign load = tx_en & ((state_q == ST_IDLE) |
                         ((state_q == ST_ACTIVE) & (bit_cnt_q == BIT_LAST)));

  // An empty load slot still sends a code so the line never gaps
  assign enc_data = sym_valid ? sym_data : D0_0;
  assign enc_k    = sym_valid & sym_k;

  encoder_8b_10b u_enc (
    .data   (enc_data),
    .k      (enc_k),
    .rd_in  (rd_q),
    .code   (shift_d),
    .rd_out (rd_d),
    .k_err  (k_err_d)
  );

  always_ff @(posedge clk_w_x10 or negedge rstn_asyn) begin
    if (!rstn_asyn) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rd_q        <= 1'b0;
      data_bit_q  <= 1'b0;
      tx_active_q <= 1'b0;
      sym_start_q <= 1'b0;
      underrun_q  <= 1'b0;
      code_err_q  <= 1'b0;
    end else begin
      sym_start_q <= 1'b0;
      underrun_q  <= 1'b0;
      code_err_q  <= 1'b0;
      if (load) begin
        state_q     <= ST_ACTIVE;
        bit_cnt_q   <= '0;
        tx_shift_q  <= shift_d;
        rd_q        <= rd_d;
        data_bit_q  <= shift_d[0];
        tx_active_q <= 1'b1;
        sym_start_q <= 1'b1;
        underrun_q  <= ~sym_valid;
        code_err_q  <= k_err_d;
      end else if (state_q == ST_ACTIVE) begin
        if (bit_cnt_q == BIT_LAST) begin
          state_q     <= ST_IDLE;
          bit_cnt_q   <= '0;
          data_bit_q  <= 1'b0;
          tx_active_q <= 1'b0;
        end else begin
          bit_cnt_q  <= bit_cnt_q + 4'd1;
          tx_shift_q <= tx_shift_q >> 1;
          data_bit_q <= tx_shift_q[1];
        end
      end
    end
  end

  assign sym_ready = load;
  assign data_bit  = data_bit_q;
  assign tx_active = tx_active_q;
  assign sym_start = sym_start_q;
  assign underrun  = underrun_q;
  assign code_err  = code_err_q;

endmodule
